// File: rtl/clock_ui_ctrl.sv
`default_nettype none
// ============================================================================
// clock_ui_ctrl : key debounce, mode FSM, stopwatch run/stop, alarm ring/snooze.
// Optional feature macro: CLOCK_UI_AUTOREPEAT_EN (inc-key auto-repeat). Rev 1.0
// ============================================================================
module clock_ui_ctrl #(
    parameter int unsigned DEBOUNCE_CYC     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYC = 25000000,
    parameter int unsigned REPEAT_RATE_CYC  = 5000000,
    parameter int unsigned RING_SEC         = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic       tick_1hz,
    input  logic       alarm_match,
    output logic [1:0] select,
    output logic [1:0] change_select,
    output logic       inc_pulse,
    output logic       sw_run,
    output logic       alarm_ring,
    output logic       alarm_led
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int RING_W = $clog2(RING_SEC + 1);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        STOPWATCH = 2'd3
    } mode_e;

    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]        deb_q, deb_d, press_q, press_d;
    logic [DB_W-1:0]   db_cnt_q [4];
    logic [DB_W-1:0]   db_cnt_d [4];
    mode_e             state_q, state_d;
    logic [1:0]        field_q, field_d;
    logic              inc_q, inc_d, run_q, run_d;
    logic              ring_q, ring_d, led_q, led_d, prev_match_q, prev_match_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              set_mode, ring_start, consumed, rpt_fire;
    logic              mode_ev, field_ev, inc_ev, run_ev;
    logic [3:0]        act;

    // Key levels are tracked as "pressed = 1" after the synchronizer.
    always_comb begin
        sync1_d = ~key_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = deb_d & ~deb_q;
    end

    // Event decode: a press during (or coinciding with the start of) a ring only snoozes.
    always_comb begin
        set_mode   = (state_q == SET_TIME) || (state_q == SET_ALARM);
        ring_start = tick_1hz && alarm_match && !prev_match_q && !ring_q;
        consumed   = (|press_q) && (ring_q || ring_start);
        act        = consumed ? 4'b0000 : press_q;
        mode_ev    = act[0];
        field_ev   = act[1] && !act[0];
        inc_ev     = act[2] && !(|act[1:0]);
        run_ev     = act[3] && !(|act[2:0]);
    end

`ifdef CLOCK_UI_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RPT_W = $clog2(RPT_MAX) + 1;

    logic             rpt_on_q, rpt_on_d, rpt_rate_q, rpt_rate_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Counter holds the cycle index since the last pulse; first period is the hold delay.
    always_comb begin
        rpt_on_d   = rpt_on_q;
        rpt_rate_d = rpt_rate_q;
        rpt_cnt_d  = rpt_cnt_q;
        rpt_fire   = 1'b0;
        if (inc_ev && set_mode) begin
            rpt_on_d   = 1'b1;
            rpt_rate_d = 1'b0;
            rpt_cnt_d  = RPT_W'(1);
        end else if (rpt_on_q) begin
            if (!deb_q[2] || !set_mode || mode_ev || ring_q || ring_start) begin
                rpt_on_d  = 1'b0;
                rpt_cnt_d = '0;
            end else if (rpt_cnt_q == (rpt_rate_q ? RPT_W'(REPEAT_RATE_CYC)
                                                  : RPT_W'(REPEAT_DELAY_CYC))) begin
                rpt_fire   = 1'b1;
                rpt_rate_d = 1'b1;
                rpt_cnt_d  = RPT_W'(1);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_on_q   <= 1'b0;
            rpt_rate_q <= 1'b0;
            rpt_cnt_q  <= '0;
        end else begin
            rpt_on_q   <= rpt_on_d;
            rpt_rate_q <= rpt_rate_d;
            rpt_cnt_q  <= rpt_cnt_d;
        end
    end
`else
    always_comb rpt_fire = 1'b0;

    // Without auto-repeat the repeat timing parameters have no effect.
    if (REPEAT_RATE_CYC > REPEAT_DELAY_CYC) begin : g_rpt_timing_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        run_d   = run_q;
        inc_d   = (inc_ev && set_mode) || rpt_fire;
        if (mode_ev) begin
            case (state_q)
                NORMAL:    state_d = SET_TIME;
                SET_TIME:  state_d = SET_ALARM;
                SET_ALARM: state_d = STOPWATCH;
                default:   state_d = NORMAL;
            endcase
            field_d = 2'd0;
            run_d   = 1'b0;
        end else if (field_ev && set_mode) begin
            field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        end else if (run_ev && (state_q == STOPWATCH)) begin
            run_d = !run_q;
        end

        prev_match_d = tick_1hz ? alarm_match : prev_match_q;
        ring_d       = ring_q;
        led_d        = led_q;
        ring_cnt_d   = ring_cnt_q;
        if (consumed) begin
            ring_d     = 1'b0;
            led_d      = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_start) begin
            ring_d     = 1'b1;
            led_d      = 1'b1;
            ring_cnt_d = RING_W'(RING_SEC);
        end else if (ring_q && tick_1hz) begin
            if (ring_cnt_q <= RING_W'(1)) begin
                ring_d     = 1'b0;
                led_d      = 1'b0;
                ring_cnt_d = '0;
            end else begin
                ring_cnt_d = ring_cnt_q - 1'b1;
                led_d      = !led_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            press_q      <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            state_q      <= NORMAL;
            field_q      <= 2'd0;
            inc_q        <= 1'b0;
            run_q        <= 1'b0;
            ring_q       <= 1'b0;
            led_q        <= 1'b0;
            prev_match_q <= 1'b0;
            ring_cnt_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            press_q      <= press_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q      <= state_d;
            field_q      <= field_d;
            inc_q        <= inc_d;
            run_q        <= run_d;
            ring_q       <= ring_d;
            led_q        <= led_d;
            prev_match_q <= prev_match_d;
            ring_cnt_q   <= ring_cnt_d;
        end
    end

    assign select        = state_q;
    assign change_select = field_q;
    assign inc_pulse     = inc_q;
    assign sw_run        = run_q;
    assign alarm_ring    = ring_q;
    assign alarm_led     = led_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_ui_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clock_ui_ctrl : directed self-checking bench for clock_ui_ctrl.  Rev 1.0
// ============================================================================
module tb_clock_ui_ctrl;
    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;
    localparam int RSEC  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       tick_1hz = 1'b0;
    logic       alarm_match = 1'b0;
    logic [1:0] select, change_select;
    logic       inc_pulse, sw_run, alarm_ring, alarm_led;

    int checks   = 0;
    int failures = 0;
    int inc_cnt  = 0;

    clock_ui_ctrl #(
        .DEBOUNCE_CYC     (DEB),
        .REPEAT_DELAY_CYC (RDLY),
        .REPEAT_RATE_CYC  (RRATE),
        .RING_SEC         (RSEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .tick_1hz      (tick_1hz),
        .alarm_match   (alarm_match),
        .select        (select),
        .change_select (change_select),
        .inc_pulse     (inc_pulse),
        .sw_run        (sw_run),
        .alarm_ring    (alarm_ring),
        .alarm_led     (alarm_led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inc_pulse === 1'b1) inc_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        step(10);
        key_n[k] = 1'b1;
        step(10);
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         base, first, n, np, t_sel, t_sw;
        int         pos[8];
        int         exp_pos[4];
        logic [4:0] exp_ring, exp_led;

        step(3);
        rst = 1'b0;
        check("rst_select", 32'(select), 0);
        check("rst_change_select", 32'(change_select), 0);
        check("rst_inc_pulse", 32'(inc_pulse), 0);
        check("rst_sw_run", 32'(sw_run), 0);
        check("rst_alarm_ring", 32'(alarm_ring), 0);
        check("rst_alarm_led", 32'(alarm_led), 0);

        // Mode cycling from reset
        for (int m = 1; m <= 4; m++) begin
            press(0);
            check("mode_cycle", 32'(select), m % 4);
        end

        // Field and inc ignored in NORMAL
        press(1);
        check("field_in_normal", 32'(change_select), 0);
        base = inc_cnt;
        press(2);
        check("inc_in_normal", inc_cnt - base, 0);

        // Field cycling in SET_TIME
        press(0);
        check("enter_set_time", 32'(select), 1);
        press(1);
        press(1);
        check("field_two", 32'(change_select), 2);
        press(1);
        check("field_wrap", 32'(change_select), 0);
        press(1);
        press(1);
        press(0);
        check("field_clear_on_mode", 32'(change_select), 0);
        press(0);
        press(0);
        press(0);
        check("mode_round_trip_sel", 32'(select), 1);
        check("mode_round_trip_cs", 32'(change_select), 0);

        // Bounce: 3 low, 1 high, then stable low
        base  = inc_cnt;
        first = -1;
        key_n[2] = 1'b0;
        step(3);
        key_n[2] = 1'b1;
        step(1);
        key_n[2] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (inc_pulse === 1'b1 && first < 0) first = i;
        end
        key_n[2] = 1'b1;
        step(12);
        check("bounce_latency", first, 7);
        check("bounce_count", inc_cnt - base, 1);

        // Priority: mode and inc in the same cycle
        base = inc_cnt;
        key_n[0] = 1'b0;
        key_n[2] = 1'b0;
        step(10);
        key_n = 4'hF;
        step(10);
        check("prio_select", 32'(select), 2);
        check("prio_no_inc", inc_cnt - base, 0);

        // Stopwatch run/stop
        press(0);
        check("enter_stopwatch", 32'(select), 3);
        press(3);
        check("sw_run_on", 32'(sw_run), 1);
        press(3);
        check("sw_run_off", 32'(sw_run), 0);
        press(3);
        check("sw_run_on_again", 32'(sw_run), 1);
        t_sel = -1;
        t_sw  = -1;
        key_n[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (select !== 2'd3 && t_sel < 0) t_sel = i;
            if (sw_run !== 1'b1 && t_sw < 0) t_sw = i;
        end
        key_n[0] = 1'b1;
        step(10);
        check("sw_leave_select", 32'(select), 0);
        check("sw_leave_run", 32'(sw_run), 0);
        check("sw_leave_sel_edge", t_sel, 7);
        check("sw_leave_run_edge", t_sw, 7);
        press(3);
        check("run_in_normal", 32'(sw_run), 0);

        // Alarm ring: match held across 5 ticks
        exp_ring    = 5'b00111;
        exp_led     = 5'b00101;
        alarm_match = 1'b1;
        for (int t = 0; t < 5; t++) begin
            do_tick();
            check("ring_seq", 32'(alarm_ring), 32'(exp_ring[t]));
            check("led_seq", 32'(alarm_led), 32'(exp_led[t]));
            step(3);
        end
        alarm_match = 1'b0;
        do_tick();
        step(2);

        // Alarm snooze by inc press in SET_TIME
        press(0);
        check("snooze_setup_sel", 32'(select), 1);
        base        = inc_cnt;
        alarm_match = 1'b1;
        do_tick();
        check("snooze_ring_start", 32'(alarm_ring), 1);
        press(2);
        check("snooze_ring_off", 32'(alarm_ring), 0);
        check("snooze_led_off", 32'(alarm_led), 0);
        check("snooze_select", 32'(select), 1);
        check("snooze_no_inc", inc_cnt - base, 0);
        do_tick();
        step(2);
        do_tick();
        check("snooze_no_rering", 32'(alarm_ring), 0);
        alarm_match = 1'b0;
        do_tick();
        step(2);

        // Dismiss arriving on the same cycle as the ring-start tick
        base        = inc_cnt;
        alarm_match = 1'b1;
        key_n[2]    = 1'b0;
        step(6);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("dismiss_wins", 32'(alarm_ring), 0);
        key_n[2] = 1'b1;
        step(10);
        do_tick();
        check("dismiss_no_later_ring", 32'(alarm_ring), 0);
        check("dismiss_no_inc", inc_cnt - base, 0);
        alarm_match = 1'b0;
        do_tick();
        step(2);

        // Auto-repeat: offsets measured from the first pulse
        key_n[2] = 1'b0;
        n = 0;
        while (inc_pulse !== 1'b1 && n < 12) begin
            step(1);
            n++;
        end
        check("rpt_first_pulse", n, 7);
        np = 0;
        for (int k = 0; k < 8; k++) pos[k] = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 32) key_n[2] = 1'b1;
            step(1);
            if (inc_pulse === 1'b1) begin
                if (np < 8) pos[np] = i;
                np++;
            end
        end
        step(10);
`ifdef CLOCK_UI_AUTOREPEAT_EN
        exp_pos = '{20, 25, 30, 35};
        check("rpt_count", np, 4);
        for (int k = 0; k < 4; k++) check("rpt_offset", pos[k], exp_pos[k]);
`else
        check("rpt_count", np, 0);
`endif

        // Reset in the middle of a hold
        key_n[2] = 1'b0;
        step(29);
        check("midhold_pre_select", 32'(select), 1);
        rst = 1'b1;
        step(1);
        check("midhold_select", 32'(select), 0);
        check("midhold_change_select", 32'(change_select), 0);
        check("midhold_inc_pulse", 32'(inc_pulse), 0);
        check("midhold_sw_run", 32'(sw_run), 0);
        check("midhold_alarm_ring", 32'(alarm_ring), 0);
        check("midhold_alarm_led", 32'(alarm_led), 0);
        rst      = 1'b0;
        key_n[2] = 1'b1;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_ui_ctrl.md
# clock_ui_ctrl

Front-panel controller for the 24-hour clock datapath. Debounces four push-buttons and runs the mode state machine that drives the clock's `select` / `change_select` inputs and produces its increment strobe. Owns stopwatch run/stop and the alarm ring/snooze sequencing. Sits between the board keys and the clock/display datapath; all outputs are registered in the `clk` domain.

## Interface
- `DEBOUNCE_CYC`, 1000000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- `REPEAT_DELAY_CYC`, 25000000: hold time before auto-repeat starts.
- `REPEAT_RATE_CYC`, 5000000: auto-repeat period.
- `RING_SEC`, 30: alarm ring duration in `tick_1hz` pulses.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: synchronous, active-high reset.
- `key_n` input 4: raw active-low buttons, asynchronous; bit0 mode, bit1 field, bit2 inc, bit3 run.
- `tick_1hz` input 1: one-cycle pulse per second from the timebase.
- `alarm_match` input 1: level, high while current time equals alarm time.
- `select` output 2: 0 normal, 1 set time, 2 set alarm, 3 stopwatch.
- `change_select` output 2: 0 sec, 1 min, 2 hour; never 3.
- `inc_pulse` output 1: one-cycle increment strobe to the datapath.
- `sw_run` output 1: stopwatch counting enable.
- `alarm_ring` output 1: high while the alarm is ringing.
- `alarm_led` output 1: `alarm_ring` blinking; toggles on each `tick_1hz`.

## Operation
- Per key: 2-flop synchronizer, then a counter. The debounced level takes the synchronized value after it has differed from the debounced level for `DEBOUNCE_CYC` consecutive cycles. Any bounce back clears the counter.
- Press event: one-cycle pulse when the debounced level goes released→pressed. Release produces no event.
- Mode FSM states: NORMAL → SET_TIME → SET_ALARM → STOPWATCH → NORMAL. It advances on a mode press. `select` equals the state encoding.
- `change_select` is cleared to 0 on every mode change.
- Field press in SET_TIME / SET_ALARM: `change_select` cycles 0→1→2→0. The field key is ignored in the other modes.
- Inc press in SET_TIME / SET_ALARM: `inc_pulse` is asserted for one cycle. The inc key is ignored in NORMAL and STOPWATCH.
- Run press in STOPWATCH toggles `sw_run`. Leaving STOPWATCH clears `sw_run` in the same cycle the state changes.
- Alarm ring:
  - Starts on a `tick_1hz` with `alarm_match`=1 while the ring is idle and the previous tick sampled `alarm_match`=0. One match window gives exactly one ring.
  - Loads the ring counter with `RING_SEC`, sets `alarm_ring`=1 and `alarm_led`=1.
  - Each tick decrements the counter and toggles `alarm_led`. When the counter reaches 0, `alarm_ring`=0 and `alarm_led`=0.
  - Any key press during a ring dismisses it (snooze). That press is consumed and has no mode/field/inc/run effect.
- Simultaneous press events in one cycle: mode beats field, field beats inc, inc beats run. Only the highest-priority event acts; the others are dropped.
- Ring start and dismiss in the same cycle: dismiss wins, so no ring occurs for that match.
- Reset:
  - Outputs: `select`=0, `change_select`=0, `inc_pulse`=0, `sw_run`=0, `alarm_ring`=0, `alarm_led`=0.
  - Debounced levels = released, all counters = 0, previous-match flag = 0.
  - A key held through reset yields one press event `DEBOUNCE_CYC`+2 cycles after `rst` falls.

## Timing
- Key press to event: 2 sync cycles + `DEBOUNCE_CYC` cycles. The resulting output change is registered one cycle later.
- `inc_pulse` width: exactly 1 cycle. Minimum spacing between pulses is `REPEAT_RATE_CYC`.
- `tick_1hz` to `alarm_ring` / `alarm_led` change: 1 cycle.
- Ring counter width: `$clog2(RING_SEC+1)` bits. Debounce and repeat counters: `$clog2` of their parameter + 1 bits. No counter wraps; each saturates or reloads.

## Configuration
- `CLOCK_UI_AUTOREPEAT_EN` defined:
  - After the inc key has been held `REPEAT_DELAY_CYC` cycles past its press event, `inc_pulse` repeats every `REPEAT_RATE_CYC` cycles until release or a mode change.
  - Repeat is active only in SET modes and never while ringing.
- Undefined: exactly one `inc_pulse` per press; no repeat counters are synthesized.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=4, `REPEAT_DELAY_CYC`=20, `REPEAT_RATE_CYC`=5, `RING_SEC`=3.
- Bounce: inc glitches low 3 cycles, high 1 cycle, then low 10 cycles in SET_TIME → exactly one `inc_pulse`, 7 cycles after the stable low starts.
- Mode cycling: 4 clean mode presses from reset → `select` goes 1,2,3,0. After field, field, mode, mode, mode, mode → `change_select`=0.
- Stopwatch: in STOPWATCH, press run → `sw_run`=1. Press mode → `select`=0 and `sw_run`=0 on the same edge.
- Alarm: `alarm_match` held high across 5 ticks → `alarm_ring` high for exactly 3 ticks, `alarm_led` pattern 1,0,1 then 0, no second ring. Repeat the run with an inc press at tick 1 → ring ends, `select` unchanged, no `inc_pulse`.
- Priority: mode and inc events in the same cycle in SET_TIME → `select`=2, no `inc_pulse`.
- Auto-repeat (macro on): inc held 40 cycles past its event → pulses at +1, +21, +26, +31, +36. With the macro off → a single pulse. Assert `rst` mid-hold → all outputs 0 next cycle.
